// File: rtl/image_sprite_fetch.sv
// Turns image-space coordinates into frame-BRAM reads and expands the RGB565 result to RGB888.
// Pixel and timing outputs appear 1 + BRAM_LATENCY cycles after the input sample.
// No backpressure: one sample is accepted every cycle and the pipeline never stalls.
module image_sprite_fetch #(
    parameter int IMG_WIDTH    = 240,
    parameter int IMG_HEIGHT   = 320,
    parameter int BRAM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] scaled_hcount_in,
    input  logic [9:0]  scaled_vcount_in,
    input  logic        valid_addr_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    output logic [16:0] bram_addr_out,
    input  logic [15:0] bram_data_in,
    output logic [23:0] pixel_out,
    output logic        pixel_valid_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        frame_done_out,
    output logic [16:0] pixel_count_out
);

    localparam int          NPIX      = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [16:0] NPIX17    = 17'(NPIX);
    localparam logic [16:0] LAST_ADDR = 17'(NPIX - 1);
    localparam logic [10:0] W11       = 11'(IMG_WIDTH);
    localparam logic [9:0]  H10       = 10'(IMG_HEIGHT);

    // Side-band bits that ride alongside the BRAM read.
    typedef struct packed {
        logic rng;
        logic last;
        logic hs;
        logic vs;
        logic bl;
    } tm_t;

    logic        in_range;
    logic [16:0] addr_calc;
    tm_t         a_bits;
    tm_t         dly [BRAM_LATENCY];
    tm_t         o_bits;
    logic        vs_prev;
    logic        vs_rise;

    assign in_range = valid_addr_in && (scaled_hcount_in < W11) && (scaled_vcount_in < H10);

    generate
        if (IMG_WIDTH == 240) begin : g_shift_add
            logic [16:0] v17;
            logic [16:0] h17;
            assign v17 = {7'b0, scaled_vcount_in};
            assign h17 = {6'b0, scaled_hcount_in};
            // v*240 = v*256 - v*16, kept in fabric adders
            assign addr_calc = (v17 << 8) - (v17 << 4) + h17;
        end else begin : g_mult
            assign addr_calc = ({7'b0, scaled_vcount_in} * 17'(IMG_WIDTH)) + {6'b0, scaled_hcount_in};
        end
    endgenerate

    // Stage A: register the read address and qualify the sample.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bram_addr_out <= '0;
            a_bits        <= '0;
        end else begin
            bram_addr_out <= in_range ? addr_calc : '0;
            a_bits        <= '{rng:  in_range,
                               last: in_range && (addr_calc == LAST_ADDR),
                               hs:   hsync_in,
                               vs:   vsync_in,
                               bl:   blank_in};
        end
    end

    // Delay line matching the BRAM read latency.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < BRAM_LATENCY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= a_bits;
            for (int i = 1; i < BRAM_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign o_bits          = dly[BRAM_LATENCY-1];
    assign pixel_valid_out = o_bits.rng;
    assign hsync_out       = o_bits.hs;
    assign vsync_out       = o_bits.vs;
    assign blank_out       = o_bits.bl;
    assign frame_done_out  = o_bits.rng && o_bits.last;
    assign vs_rise         = vsync_out && !vs_prev;

    // RGB565 -> RGB888 by replicating the top bits into the new LSBs.
    always_comb begin
        pixel_out = '0;
        if (o_bits.rng)
            pixel_out = {bram_data_in[15:11], bram_data_in[15:13],
                         bram_data_in[10:5],  bram_data_in[10:9],
                         bram_data_in[4:0],   bram_data_in[4:2]};
    end

    // Per-frame valid pixel counter; a vsync_out rise restarts it and beats a same-cycle pixel.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vs_prev         <= 1'b0;
            pixel_count_out <= '0;
        end else begin
            vs_prev <= vsync_out;
            if (vs_rise)
                pixel_count_out <= '0;
            else if (pixel_valid_out && (pixel_count_out < NPIX17))
                pixel_count_out <= pixel_count_out + 17'd1;
        end
    end

endmodule

// File: tb/tb_image_sprite_fetch.sv
module tb_image_sprite_fetch;

    localparam int W    = 240;
    localparam int H    = 320;
    localparam int BL   = 2;
    localparam int L    = 1 + BL;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        vld;
        logic        hs;
        logic        vs;
        logic        bl;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [16:0] a;
        logic [23:0] pix;
        logic        pv;
        logic        fd;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] scaled_hcount_in = '0;
    logic [9:0]  scaled_vcount_in = '0;
    logic        valid_addr_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        blank_in = 1'b0;
    logic [16:0] bram_addr_out;
    logic [15:0] bram_data_in;
    logic [23:0] pixel_out;
    logic        pixel_valid_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;
    logic        frame_done_out;
    logic [16:0] pixel_count_out;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;
    stim_t hist[$];
    int unsigned cnt_m = 0;
    logic vs_prev_m = 1'b0;
    vec_t tbl[7];

    image_sprite_fetch #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BRAM_LATENCY(BL)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .scaled_hcount_in(scaled_hcount_in), .scaled_vcount_in(scaled_vcount_in),
        .valid_addr_in(valid_addr_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .blank_in(blank_in), .bram_addr_out(bram_addr_out), .bram_data_in(bram_data_in),
        .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .blank_out(blank_out), .frame_done_out(frame_done_out),
        .pixel_count_out(pixel_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Frame BRAM contents as a pure function of address.
    function automatic logic [15:0] bram_word(input int unsigned a);
        logic [31:0] a32;
        a32 = a;
        if (a == 76799) return 16'hFFFF;
        return a32[15:0] ^ 16'hF800;
    endfunction

    // Fixed-latency BRAM model driven by the DUT's read address.
    logic [16:0] aq0 = '0;
    logic [16:0] aq1 = '0;
    always @(posedge clk_in) begin
        aq0 <= bram_addr_out;
        aq1 <= aq0;
    end
    assign bram_data_in = bram_word(int'(aq1));

    function automatic stim_t mk(input int h, input int v, input logic vld,
                                 input logic hs, input logic vs, input logic bl);
        stim_t s;
        s.h = 11'(h); s.v = 10'(v); s.vld = vld; s.hs = hs; s.vs = vs; s.bl = bl;
        return s;
    endfunction

    function automatic logic in_rng(input stim_t s);
        return s.vld && (int'(s.h) < W) && (int'(s.v) < H);
    endfunction

    function automatic int unsigned addr_of(input stim_t s);
        return in_rng(s) ? (int'(s.v) * W + int'(s.h)) : 0;
    endfunction

    function automatic logic [23:0] expand(input logic [15:0] d);
        logic [7:0] r, g, b;
        r = {d[15:11], d[15:13]};
        g = {d[10:5], d[10:9]};
        b = {d[4:0], d[4:2]};
        return {r, g, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        scaled_hcount_in = s.h;
        scaled_vcount_in = s.v;
        valid_addr_in    = s.vld;
        hsync_in         = s.hs;
        vsync_in         = s.vs;
        blank_in         = s.bl;
    endtask

    // One clock: check this cycle's outputs against the model, then apply the next sample.
    task automatic cycle(input stim_t s);
        stim_t sa, so;
        logic ev;
        int unsigned ao;
        @(posedge clk_in);
        #1;
        sa = hist[hist.size()-1];
        so = hist[hist.size()-L];
        ev = in_rng(so);
        ao = addr_of(so);
        chk("addr", 32'(bram_addr_out), addr_of(sa));
        chk("pixel_valid", 32'(pixel_valid_out), 32'(ev));
        chk("pixel", 32'(pixel_out), ev ? 32'(expand(bram_word(ao))) : 32'd0);
        chk("hsync", 32'(hsync_out), 32'(so.hs));
        chk("vsync", 32'(vsync_out), 32'(so.vs));
        chk("blank", 32'(blank_out), 32'(so.bl));
        chk("frame_done", 32'(frame_done_out), 32'(ev && (ao == NPIX - 1)));
        chk("count", 32'(pixel_count_out), cnt_m);
        if (frame_done_out === 1'b1) fd_seen++;
        if (so.vs && !vs_prev_m) cnt_m = 0;
        else if (ev && cnt_m < NPIX) cnt_m++;
        vs_prev_m = so.vs;
        drive(s);
        hist.push_back(s);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic do_reset();
        stim_t z;
        z = '0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        drive(z);
        #1;
        chk("rst_addr", 32'(bram_addr_out), 0);
        chk("rst_pixel", 32'(pixel_out), 0);
        chk("rst_valid", 32'(pixel_valid_out), 0);
        chk("rst_hsync", 32'(hsync_out), 0);
        chk("rst_vsync", 32'(vsync_out), 0);
        chk("rst_blank", 32'(blank_out), 0);
        chk("rst_fd", 32'(frame_done_out), 0);
        chk("rst_count", 32'(pixel_count_out), 0);
        hist.delete();
        for (int i = 0; i < L + 1; i++) hist.push_back(z);
        cnt_m = 0;
        vs_prev_m = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        stim_t idle;
        idle = '0;

        tbl[0] = '{s: mk(0, 0, 1, 0, 0, 0),     a: 17'd0,     pix: 24'hFF0000, pv: 1'b1, fd: 1'b0};
        tbl[1] = '{s: mk(239, 319, 1, 0, 0, 0), a: 17'd76799, pix: 24'hFFFFFF, pv: 1'b1, fd: 1'b1};
        tbl[2] = '{s: mk(240, 10, 1, 0, 0, 0),  a: 17'd0,     pix: 24'h000000, pv: 1'b0, fd: 1'b0};
        tbl[3] = '{s: mk(5, 1, 0, 0, 0, 0),     a: 17'd0,     pix: 24'h000000, pv: 1'b0, fd: 1'b0};
        tbl[4] = '{s: mk(10, 320, 1, 0, 0, 0),  a: 17'd0,     pix: 24'h000000, pv: 1'b0, fd: 1'b0};
        tbl[5] = '{s: mk(1, 1, 1, 0, 0, 0),     a: 17'd241,   pix: 24'hFF1C8C, pv: 1'b1, fd: 1'b0};
        tbl[6] = '{s: mk(239, 0, 1, 0, 0, 0),   a: 17'd239,   pix: 24'hFF1C7B, pv: 1'b1, fd: 1'b0};

        do_reset();

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].s);
            cycle(idle);
            chk("tbl_addr", 32'(bram_addr_out), 32'(tbl[i].a));
            cycle(idle);
            cycle(idle);
            chk("tbl_pixel", 32'(pixel_out), 32'(tbl[i].pix));
            chk("tbl_valid", 32'(pixel_valid_out), 32'(tbl[i].pv));
            chk("tbl_fd", 32'(frame_done_out), 32'(tbl[i].fd));
            cycle(idle);
            chk("tbl_fd_one_cycle", 32'(frame_done_out), 0);
        end

        // Timing pass-through pattern.
        for (int i = 0; i < 24; i++)
            cycle(mk(i, 2, 1, logic'((i / 3) % 2), 1'b0, logic'((i % 5) == 0)));

        // Reset with the last pixel in flight: it must never produce frame_done.
        fd_seen = 0;
        cycle(mk(239, 319, 1, 0, 0, 0));
        cycle(idle);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(idle);
        chk("inflight_fd_dropped", 32'(fd_seen), 0);

        // Partial raster, reset mid-raster, then resume.
        for (int i = 0; i < 500; i++) cycle(mk(i % W, i / W, 1, 0, 0, 0));
        do_reset();
        for (int i = 500; i < 600; i++) cycle(mk(i % W, i / W, 1, 0, 0, 0));

        // Full frame raster.
        do_reset();
        fd_seen = 0;
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++)
                cycle(mk(h, v, 1, logic'(h < 8), 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) cycle(idle);
        chk("raster_count", 32'(pixel_count_out), 76800);
        chk("raster_fd_once", 32'(fd_seen), 1);

        // Repeated last address: fires every time, count stays saturated.
        for (int i = 0; i < 3; i++) cycle(mk(239, 319, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) cycle(idle);
        chk("repeat_fd", 32'(fd_seen), 4);
        chk("count_saturated", 32'(pixel_count_out), 76800);

        // Frame boundary clears the count.
        cycle(mk(0, 0, 0, 0, 1, 0));
        cycle(idle);
        cycle(idle);
        cycle(idle);
        chk("vs_rise_seen", 32'(vsync_out), 1);
        chk("count_before_clear", 32'(pixel_count_out), 76800);
        cycle(idle);
        chk("count_cleared", 32'(pixel_count_out), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            stim_t s;
            if ($urandom_range(0, 19) == 0)
                s = mk(239, 319, 1, 1'($urandom), 1'b0, 1'($urandom));
            else
                s = mk(int'($urandom_range(0, 250)), int'($urandom_range(0, 330)),
                       logic'($urandom_range(0, 9) != 0), 1'($urandom),
                       logic'($urandom_range(0, 30) == 0), 1'($urandom));
            cycle(s);
        end
        for (int i = 0; i < 4; i++) cycle(idle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
